// File: rtl/step_ctrl_pkg.sv
// Shared types and constants for the step/run enable controller.
package step_ctrl_pkg;

    // Controller state: single-step on button presses, or free-running on the prescaler.
    typedef enum logic {
        S_STEP = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // Flops in each raw-input synchronizer chain.
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/step_ctrl_debounce.sv
// Synchronizer plus debouncer for one raw board input; output is the accepted stable level.
module debounce
    import step_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic stable_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  synced;
    logic                  stable_q, stable_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    assign synced   = sync_q[SYNC_DEPTH-1];
    assign stable_o = stable_q;

    // Bring the asynchronous input into the clock domain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_DEPTH-2:0], raw_i};
    end

    // Count consecutive disagreeing cycles; accept the new level once the count has reached DB_CYCLES.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q + 1'b1;
        if (synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DB_CYCLES)) begin
            stable_d = synced;
            cnt_d    = '0;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// Produces the single-cycle enable strobe for the event counter: one pulse per clean
// button press in STEP mode, one pulse every DIV clocks in RUN mode.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int DIV       = 100_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    input  logic run_sw,
    output logic enable,
    output logic run_active
);

    localparam int PW = $clog2(DIV);

    logic          btn_db, run_db;
    logic          btn_prev_q;
    logic          btn_rise;
    logic          tick;
    logic [PW-1:0] pre_q, pre_d;
    state_t        state_q;
    logic          enable_q, run_active_q;

    debounce #(.DB_CYCLES(DB_CYCLES)) u_btn_db (
        .clock    (clock),
        .reset    (reset),
        .raw_i    (btn_raw),
        .stable_o (btn_db)
    );

    debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
        .clock    (clock),
        .reset    (reset),
        .raw_i    (run_sw),
        .stable_o (run_db)
    );

    assign btn_rise   = btn_db & ~btn_prev_q;
    assign tick       = (state_q == S_RUN) && (pre_q == PW'(DIV - 1));
    assign enable     = enable_q;
    assign run_active = run_active_q;

    // Previous debounced button level for press detection; release is ignored.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) btn_prev_q <= 1'b0;
        else       btn_prev_q <= btn_db;
    end

    // Prescaler idles at zero outside RUN so every entry into RUN starts a full period.
    always_comb begin
        pre_d = pre_q + 1'b1;
        if (state_q != S_RUN || tick) pre_d = '0;
    end

    // Prescaler register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) pre_q <= '0;
        else       pre_q <= pre_d;
    end

    // Mode FSM with registered enable and run_active; the enable rule also gates on the
    // debounced switch so a press or tick coinciding with a mode change is dropped.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_STEP;
            enable_q     <= 1'b0;
            run_active_q <= 1'b0;
        end else begin
            case (state_q)
                S_STEP: begin
                    enable_q <= btn_rise & ~run_db;
                    if (run_db) begin
                        state_q      <= S_RUN;
                        run_active_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    enable_q <= tick & run_db;
                    if (!run_db) begin
                        state_q      <= S_STEP;
                        run_active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= S_STEP;
                    enable_q     <= 1'b0;
                    run_active_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/step_ctrl.md
# step_ctrl

Generates the single-cycle `enable` strobe that drives the 4-bit event counter. It takes two raw board inputs, a push-button and a run switch, and synchronizes and debounces both. It then runs a two-state controller: in STEP mode each clean button press yields one pulse; in RUN mode a prescaler yields one pulse every `DIV` clocks. It sits directly upstream of the counter and connects only through `enable`.

## Interface

Parameters:
- `DIV`, default 100_000_000: RUN-mode pulse period in clocks; legal range >= 2.
- `DB_CYCLES`, default 1_000_000: consecutive cycles an input must differ before it is accepted; legal range >= 2.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `btn_raw`  in  1  raw push-button; asynchronous and bouncy.
- `run_sw`  in  1  raw run/step switch (1 = RUN); asynchronous and bouncy.
- `enable`  out  1  registered single-cycle strobe to the counter.
- `run_active`  out  1  registered; high while the controller is in RUN.

## Operation

- **Input conditioning.** Each raw input passes through a 2-FF synchronizer and then a debouncer.
  - The debouncer counter clears whenever the synced value equals the stable value.
  - Otherwise the counter increments. When it has seen `DB_CYCLES` consecutive differing cycles, the stable value takes the synced value and the counter clears.
  - Debounce counter width is $clog2(DB_CYCLES+1).
- **Edge detect.** `btn_rise` = stable button is 1 and was 0 last cycle. Only rising edges matter; release produces nothing.
- **State machine**, 2 states, reset to S_STEP:
  - S_STEP -> S_RUN when debounced run = 1.
  - S_RUN -> S_STEP when debounced run = 0.
  - `run_active` equals (state == S_RUN).
- **Prescaler.**
  - Counter is $clog2(DIV) bits wide.
  - It is held at 0 whenever the state is not S_RUN.
  - In S_RUN it increments each cycle. `tick` fires when the count equals DIV-1, and the counter wraps to 0 on that cycle.
- **Enable rule**, registered from the current state:
  - In S_STEP: enable = btn_rise AND debounced run = 0.
  - In S_RUN: enable = tick AND debounced run = 1.
  - `enable` is never high for two consecutive cycles.
- **Boundary conditions.**
  - A button press in S_RUN is discarded. It is not queued.
  - A button edge in the same cycle as run going high is discarded.
  - A tick in the same cycle as run going low produces no pulse.
  - Leaving S_RUN clears the prescaler, so re-entry always starts a full `DIV` period.
  - A button held high through reset release yields exactly one pulse once debounced, because the stable value resets to 0.
  - Bounce shorter than `DB_CYCLES` produces no pulse and no state change.
- **Reset.** Asynchronous. All synchronizer flops, stable values, counters, state (S_STEP), `enable` and `run_active` go to 0 immediately. Reset asserted mid-RUN drops `enable` in the same cycle.

## Timing

- Button path: `btn_raw` rises before edge N and stays stable. Synced value appears at edge N+2, stable updates at edge N+2+DB_CYCLES, and `enable` is high for the cycle after edge N+3+DB_CYCLES. Total latency is DB_CYCLES+3 edges.
- Run path: `run_sw` rises before edge N. Debounced run is high at N+2+DB_CYCLES, and state/`run_active` go high at N+3+DB_CYCLES.
- RUN pulse: the state enters S_RUN at edge E. The first `enable` is high after edge E+DIV, then every `DIV` cycles exactly.
- Stopping: after `run_sw` falls, pulses stop no later than DB_CYCLES+3 edges.

## Structure

- Shared package `step_ctrl_pkg` holds:
  - the state encoding (S_STEP = 0, S_RUN = 1) as a 1-bit state typedef;
  - the synchronizer depth constant (2).
- One sub-module, `debounce`: synchronizer plus debouncer, parameterised by `DB_CYCLES`, output is the stable value. It is instantiated twice, once for the button and once for the switch.
- The FSM, edge detect, prescaler and enable register live in the top level.

## Test plan

All scenarios use DIV=4 and DB_CYCLES=3.

1. Reset: assert `reset` with the inputs toggling -> `enable`=0 and `run_active`=0 throughout. After release with inputs low, no pulse for 20 cycles.
2. Clean press: `run_sw`=0; `btn_raw` goes 1 before edge 10 and is held 20 cycles, then released -> exactly one `enable` pulse after edge 16; none on release.
3. Bounce: `btn_raw` toggles every cycle for 8 cycles, then holds 1 -> exactly one pulse, 6 edges after it settles. A 2-cycle glitch alone produces 0 pulses.
4. RUN mode: `run_sw`=1 from edge 5 -> `run_active` high at edge 11, and `enable` pulses at edges 15, 19 and 23. Button presses during this window produce no extra pulses.
5. Stop/restart: drop `run_sw` mid-period -> pulses stop and `run_active` falls 6 edges later. Re-raise it -> the first pulse comes exactly 4 cycles after re-entering S_RUN.
6. Reset mid-RUN: assert `reset` asynchronously in the same cycle that `enable` is high -> `enable` and `run_active` drop immediately. After release the block is in S_STEP until the switch is debounced again.
